// File: rtl/host_loader_pkg.sv
// Shared definitions for the host loader: command and status byte codes and the
// control state encoding.
package host_loader_pkg;

  localparam logic [7:0] CMD_WRITE = 8'h01;
  localparam logic [7:0] CMD_READ  = 8'h02;
  localparam logic [7:0] CMD_RUN   = 8'h03;

  localparam logic [7:0] ST_OK     = 8'hA5;
  localparam logic [7:0] ST_BADCMD = 8'hEE;

  // Header after CMD: 3 address bytes then 2 length bytes, MSB first.
  localparam logic [2:0] HDR_LAST_ADDR = 3'd2;
  localparam logic [2:0] HDR_LAST     = 3'd4;

  typedef enum logic [3:0] {
    S_IDLE,
    S_HDR,
    S_WR_BYTE,
    S_WR_MEM,
    S_RD_MEM,
    S_RD_WAIT,
    S_RD_TX,
    S_RUN,
    S_STATUS
  } state_e;

  function automatic logic is_mem_cmd(input logic [7:0] cmd);
    return (cmd == CMD_WRITE) || (cmd == CMD_READ);
  endfunction

endpackage

// File: rtl/host_loader_if.sv
// Host-link, SRAM master and tester-control signals of the host loader.
// Byte links: a byte moves on a rising edge where valid && ready; the sender holds data
// stable while valid is high and ready is low. SRAM: read/write held until waitrequest=0.
interface host_loader_if #(
  parameter int ADDR_WIDTH = 20,
  parameter int DATA_WIDTH = 16,
  parameter int BE_WIDTH   = DATA_WIDTH / 8
);
  logic [7:0]            rx_data;
  logic                  rx_valid;
  logic                  rx_ready;
  logic [7:0]            tx_data;
  logic                  tx_valid;
  logic                  tx_ready;
  logic [ADDR_WIDTH-1:0] address;
  logic [BE_WIDTH-1:0]   byteenable;
  logic                  read;
  logic [DATA_WIDTH-1:0] readdata;
  logic                  readdataready;
  logic                  write;
  logic [DATA_WIDTH-1:0] writedata;
  logic                  waitrequest;
  logic                  tester_enable;
  logic                  tester_done;
  logic                  bus_owner;

  modport master (
    input  rx_data, rx_valid, tx_ready, readdata, readdataready, waitrequest, tester_done,
    output rx_ready, tx_data, tx_valid, address, byteenable, read, write, writedata,
           tester_enable, bus_owner
  );

  modport slave (
    output rx_data, rx_valid, tx_ready, readdata, readdataready, waitrequest, tester_done,
    input  rx_ready, tx_data, tx_valid, address, byteenable, read, write, writedata,
           tester_enable, bus_owner
  );
endinterface

// File: rtl/host_byte_packer.sv
// Joins two host bytes (hi first) into a 16-bit SRAM word and splits a word back into
// its hi/lo bytes for transmission.
module host_byte_packer (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        load_hi_i,
  input  logic [7:0]  byte_i,
  input  logic [15:0] word_i,
  output logic [15:0] word_o,
  output logic [7:0]  hi_o,
  output logic [7:0]  lo_o
);
  logic [7:0] hi_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hi_q <= 8'h00;
    end else if (load_hi_i) begin
      hi_q <= byte_i;
    end
  end

  assign word_o = {hi_q, byte_i};
  assign hi_o   = word_i[15:8];
  assign lo_o   = word_i[7:0];
endmodule

// File: rtl/host_loader.sv
// Host command decoder: WRITE/READ move words between the host link and test SRAM,
// RUN hands the SRAM to the tester until it reports done. Each command ends in one status byte.
module host_loader
  import host_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 20
) (
  input  logic           clock,
  input  logic           reset_n,
  host_loader_if.master  host_io,
  output state_e         state_o
);
  state_e                state_q, state_d;
  logic [2:0]            hdr_cnt_q, hdr_cnt_d;
  logic [7:0]            cmd_q, cmd_d;
  logic [15:0]           len_q, len_d;
  logic [ADDR_WIDTH-1:0] address_q, address_d;
  logic [15:0]           writedata_q, writedata_d;
  logic [15:0]           rdata_q, rdata_d;
  logic [7:0]            tx_data_q, tx_data_d;
  logic                  byte_sel_q, byte_sel_d;
  logic                  run_first_q, run_first_d;
  logic                  armed_q;

  logic        rx_ready, tx_valid, rx_fire, tx_fire, load_hi;
  logic [15:0] len_shift, len_dec, pk_word, unpack_src;
  logic [7:0]  pk_hi, pk_lo;

  host_byte_packer u_packer (
    .clock     (clock),
    .reset_n   (reset_n),
    .load_hi_i (load_hi),
    .byte_i    (host_io.rx_data),
    .word_i    (unpack_src),
    .word_o    (pk_word),
    .hi_o      (pk_hi),
    .lo_o      (pk_lo)
  );

  // armed_q keeps rx_ready low while in reset and for the first cycle after it.
  assign rx_ready   = armed_q && (state_q inside {S_IDLE, S_HDR, S_WR_BYTE});
  assign tx_valid   = state_q inside {S_RD_TX, S_STATUS};
  assign rx_fire    = host_io.rx_valid && rx_ready;
  assign tx_fire    = tx_valid && host_io.tx_ready;
  assign len_shift  = {len_q[7:0], host_io.rx_data};
  assign len_dec    = len_q - 16'd1;
  assign unpack_src = (state_q == S_RD_WAIT) ? host_io.readdata : rdata_q;

  always_comb begin
    state_d     = state_q;
    hdr_cnt_d   = hdr_cnt_q;
    cmd_d       = cmd_q;
    len_d       = len_q;
    address_d   = address_q;
    writedata_d = writedata_q;
    rdata_d     = rdata_q;
    tx_data_d   = tx_data_q;
    byte_sel_d  = byte_sel_q;
    run_first_d = run_first_q;
    load_hi     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (rx_fire) begin
          cmd_d = host_io.rx_data;
          if (is_mem_cmd(host_io.rx_data)) begin
            hdr_cnt_d = 3'd0;
            state_d   = S_HDR;
          end else if (host_io.rx_data == CMD_RUN) begin
            run_first_d = 1'b1;
            state_d     = S_RUN;
          end else begin
            tx_data_d = ST_BADCMD;
            state_d   = S_STATUS;
          end
        end
      end
      S_HDR: begin
        if (rx_fire) begin
          hdr_cnt_d = hdr_cnt_q + 3'd1;
          // Shifting through ADDR_WIDTH bits drops address bits above the SRAM range.
          if (hdr_cnt_q <= HDR_LAST_ADDR) begin
            address_d = ADDR_WIDTH'({address_q, host_io.rx_data});
          end else begin
            len_d = len_shift;
          end
          if (hdr_cnt_q == HDR_LAST) begin
            byte_sel_d = 1'b0;
            if (len_shift == 16'd0) begin
              tx_data_d = ST_OK;
              state_d   = S_STATUS;
            end else if (cmd_q == CMD_WRITE) begin
              state_d = S_WR_BYTE;
            end else begin
              state_d = S_RD_MEM;
            end
          end
        end
      end
      S_WR_BYTE: begin
        if (rx_fire) begin
          if (!byte_sel_q) begin
            load_hi    = 1'b1;
            byte_sel_d = 1'b1;
          end else begin
            writedata_d = pk_word;
            byte_sel_d  = 1'b0;
            state_d     = S_WR_MEM;
          end
        end
      end
      S_WR_MEM: begin
        if (!host_io.waitrequest) begin
          address_d = address_q + 1'b1;
          len_d     = len_dec;
          if (len_dec == 16'd0) begin
            tx_data_d = ST_OK;
            state_d   = S_STATUS;
          end else begin
            state_d = S_WR_BYTE;
          end
        end
      end
      S_RD_MEM: begin
        if (!host_io.waitrequest) begin
          state_d = S_RD_WAIT;
        end
      end
      S_RD_WAIT: begin
        if (host_io.readdataready) begin
          rdata_d    = host_io.readdata;
          tx_data_d  = pk_hi;
          byte_sel_d = 1'b0;
          state_d    = S_RD_TX;
        end
      end
      S_RD_TX: begin
        if (tx_fire) begin
          if (!byte_sel_q) begin
            tx_data_d  = pk_lo;
            byte_sel_d = 1'b1;
          end else begin
            byte_sel_d = 1'b0;
            address_d  = address_q + 1'b1;
            len_d      = len_dec;
            if (len_dec == 16'd0) begin
              tx_data_d = ST_OK;
              state_d   = S_STATUS;
            end else begin
              state_d = S_RD_MEM;
            end
          end
        end
      end
      S_RUN: begin
        // A done level already present on entry belongs to a previous run; skip one cycle.
        run_first_d = 1'b0;
        if (!run_first_q && host_io.tester_done) begin
          tx_data_d = ST_OK;
          state_d   = S_STATUS;
        end
      end
      S_STATUS: begin
        if (tx_fire) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      hdr_cnt_q   <= 3'd0;
      cmd_q       <= 8'h00;
      len_q       <= 16'd0;
      address_q   <= '0;
      writedata_q <= 16'h0000;
      rdata_q     <= 16'h0000;
      tx_data_q   <= 8'h00;
      byte_sel_q  <= 1'b0;
      run_first_q <= 1'b0;
      armed_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      hdr_cnt_q   <= hdr_cnt_d;
      cmd_q       <= cmd_d;
      len_q       <= len_d;
      address_q   <= address_d;
      writedata_q <= writedata_d;
      rdata_q     <= rdata_d;
      tx_data_q   <= tx_data_d;
      byte_sel_q  <= byte_sel_d;
      run_first_q <= run_first_d;
      armed_q     <= 1'b1;
    end
  end

  assign host_io.rx_ready      = rx_ready;
  assign host_io.tx_valid      = tx_valid;
  assign host_io.tx_data       = tx_data_q;
  assign host_io.address       = address_q;
  assign host_io.writedata     = writedata_q;
  assign host_io.read          = (state_q == S_RD_MEM);
  assign host_io.write         = (state_q == S_WR_MEM);
  assign host_io.byteenable    = (host_io.read || host_io.write) ? '1 : '0;
  assign host_io.tester_enable = (state_q == S_RUN);
  assign host_io.bus_owner     = (state_q != S_RUN);
  assign state_o               = state_q;
endmodule
